soc_membus_arbiter: RTL and testbench

//  Shares one SoC_MemBus slave port (main memory) between two masters: m0 (UART programming

---
 rtl/soc_membus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_soc_membus_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_membus_arbiter.sv
// ---------------------------------------------------------------------------
// soc_membus_arbiter
//
// Purpose:
//   Shares a single memory bus slave port between two masters, m0 (UART
//   programming bridge) and m1 (CPU data port). One transaction runs at a
//   time. The granted master's request is mirrored onto mem_*, and valid and
//   read_data are routed back to that master only. A watchdog force-completes
//   transactions that the memory never acknowledges.
//
// Parameters:
//   RR_MODE        0: fixed priority, m0 wins ties; 1: round-robin on ties
//   TIMEOUT_CYCLES BUSY cycles before forced completion; 0 disables it
//
// Ports:
//   clk, res                 clock and asynchronous active-high reset
//   m0_* / m1_*              master-side bus: req, addr, write_en,
//                            write_data, byte_en in; read_data, valid out
//   mem_*                    memory-side bus: req, addr, write_en,
//                            write_data, byte_en out; read_data, valid in
//   grant                    one-hot owner (bit0 = m0, bit1 = m1), 00 idle
//   timeout_err              one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module soc_membus_arbiter #(
    parameter logic        RR_MODE        = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        res,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_write_en,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_byte_en,
    output logic [31:0] m0_read_data,
    output logic        m0_valid,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_write_en,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_byte_en,
    output logic [31:0] m1_read_data,
    output logic        m1_valid,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_read_data,
    input  logic        mem_valid,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01
    } state_t;

    localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    // 1 = m1 was granted last. It also selects the mirrored master while BUSY.
    logic        last_grant_q, last_grant_d;
    logic [31:0] count_q, count_d;

    logic        busy;
    logic        owner_req;
    logic        owner_we;
    logic        timeout_hit;
    logic        done;
    logic        pick_m1;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            count_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
        end
    end

    // Mirror the owner's request fields and decide whether the current BUSY
    // cycle ends the transaction. A real valid takes precedence over the
    // watchdog, so the watchdog can only fire when mem_valid is low.
    always_comb begin
        busy        = (state_q == ST_BUSY);
        owner_req   = last_grant_q ? m1_req      : m0_req;
        owner_we    = last_grant_q ? m1_write_en : m0_write_en;
        timeout_hit = busy && WD_EN && (count_q >= TO_LAST) && !mem_valid;
        done        = busy && (mem_valid || timeout_hit);

        // The memory request is dropped in the watchdog cycle so that the
        // memory never sees a request the masters believe has completed.
        mem_req        = busy && owner_req && !timeout_hit;
        mem_write_en   = busy && owner_we;
        mem_addr       = last_grant_q ? m1_addr       : m0_addr;
        mem_write_data = last_grant_q ? m1_write_data : m0_write_data;
        mem_byte_en    = last_grant_q ? m1_byte_en    : m0_byte_en;

        m0_valid     = done && !last_grant_q;
        m1_valid     = done &&  last_grant_q;
        m0_read_data = (busy && !last_grant_q && mem_valid) ? mem_read_data : 32'h0;
        m1_read_data = (busy &&  last_grant_q && mem_valid) ? mem_read_data : 32'h0;

        grant       = grant_q;
        timeout_err = timeout_hit;
    end

    // Next-state logic. In IDLE a tie is resolved by RR_MODE; in BUSY the
    // watchdog counts until completion, which always returns to IDLE so there
    // is at least one idle cycle between transactions.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        pick_m1      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) begin
                        pick_m1 = RR_MODE ? ~last_grant_q : 1'b0;
                    end else begin
                        pick_m1 = m1_req;
                    end
                    state_d      = ST_BUSY;
                    grant_d      = pick_m1 ? 2'b10 : 2'b01;
                    last_grant_d = pick_m1;
                    count_d      = 32'd0;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end else if (count_q != 32'hFFFF_FFFF) begin
                    count_d = count_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_soc_membus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_soc_membus_arbiter
//
// Purpose:
//   Self-checking bench for soc_membus_arbiter. The main instance runs with
//   round-robin and an 8-cycle watchdog. A second instance with fixed
//   priority and both requests tied high is watched for m1 starvation.
//   A transaction-level model (owner, cycles spent in the transaction,
//   memory latency) predicts every output in every cycle.
// ---------------------------------------------------------------------------
module tb_soc_membus_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        res;

    logic        m0_req, m0_write_en, m1_req, m1_write_en;
    logic [31:0] m0_addr, m0_write_data, m1_addr, m1_write_data;
    logic [3:0]  m0_byte_en, m1_byte_en;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_valid, m1_valid;
    logic        mem_req, mem_write_en, mem_valid;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_byte_en;
    logic [1:0]  grant;
    logic        timeout_err;

    logic        fp_m0_req, fp_m1_req;
    logic [31:0] fp_m0_read_data, fp_m1_read_data;
    logic        fp_m0_valid, fp_m1_valid;
    logic        fp_mem_req, fp_mem_write_en, fp_mem_valid;
    logic [31:0] fp_mem_addr, fp_mem_write_data;
    logic [3:0]  fp_mem_byte_en;
    logic [1:0]  fp_grant;
    logic        fp_timeout_err;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: own = -1 idle, 0 = m0, 1 = m1.
    int          own;
    int          k;
    int          lat;
    int          last;
    logic [31:0] txn_rdata;
    int          next_lat;
    logic        use_fixed;
    logic [31:0] fixed_rdata;

    int          cnt_g0, cnt_v0, cnt_v1, cnt_memw, cnt_to;
    int          fp_g0, fp_g1;
    logic [31:0] last_v1_rdata;
    logic [1:0]  prev_grant;
    logic [1:0]  order[$];

    soc_membus_arbiter #(.RR_MODE(1'b1), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .res(res),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_write_en(m0_write_en),
        .m0_write_data(m0_write_data), .m0_byte_en(m0_byte_en),
        .m0_read_data(m0_read_data), .m0_valid(m0_valid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_write_en(m1_write_en),
        .m1_write_data(m1_write_data), .m1_byte_en(m1_byte_en),
        .m1_read_data(m1_read_data), .m1_valid(m1_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_byte_en(mem_byte_en),
        .mem_read_data(mem_read_data), .mem_valid(mem_valid),
        .grant(grant), .timeout_err(timeout_err)
    );

    soc_membus_arbiter #(.RR_MODE(1'b0), .TIMEOUT_CYCLES(4)) dut_fp (
        .clk(clk), .res(res),
        .m0_req(fp_m0_req), .m0_addr(32'h0), .m0_write_en(1'b0),
        .m0_write_data(32'h0), .m0_byte_en(4'h0),
        .m0_read_data(fp_m0_read_data), .m0_valid(fp_m0_valid),
        .m1_req(fp_m1_req), .m1_addr(32'h0), .m1_write_en(1'b0),
        .m1_write_data(32'h0), .m1_byte_en(4'h0),
        .m1_read_data(fp_m1_read_data), .m1_valid(fp_m1_valid),
        .mem_req(fp_mem_req), .mem_addr(fp_mem_addr), .mem_write_en(fp_mem_write_en),
        .mem_write_data(fp_mem_write_data), .mem_byte_en(fp_mem_byte_en),
        .mem_read_data(32'hA5A5_A5A5), .mem_valid(fp_mem_valid),
        .grant(fp_grant), .timeout_err(fp_timeout_err)
    );

    // The fixed-priority memory acknowledges every request immediately.
    assign fp_mem_valid = fp_mem_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] order_at(input int i);
        if (i < order.size()) return order[i];
        return 2'b11;
    endfunction

    task automatic model_reset();
        own  = -1;
        k    = 0;
        last = 1;
    endtask

    // One clock cycle: drive the memory response, let logic settle, compare
    // every output against the model, advance the model, cross the edge.
    task automatic step();
        logic        fire, fin;
        logic [1:0]  e_grant;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_be;
        logic        o_req, o_we;

        mem_valid     = (own >= 0) && (k == lat);
        mem_read_data = mem_valid ? txn_rdata : $urandom;
        #1;
        fire    = (own >= 0) && !mem_valid && (k == TO - 1);
        fin     = (own >= 0) && (mem_valid || fire);
        e_grant = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
        o_req   = (own == 1) ? m1_req : m0_req;
        o_we    = (own == 1) ? m1_write_en : m0_write_en;
        e_req   = (own >= 0) && o_req && !fire;
        e_we    = (own >= 0) && o_we;
        e_addr  = (own == 1) ? m1_addr : m0_addr;
        e_wd    = (own == 1) ? m1_write_data : m0_write_data;
        e_be    = (own == 1) ? m1_byte_en : m0_byte_en;
        e_rd    = mem_valid ? txn_rdata : 32'h0;

        chk("grant", {30'd0, grant}, {30'd0, e_grant});
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
        chk("mem_write_en", {31'd0, mem_write_en}, {31'd0, e_we});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, fire});
        chk("m0_valid", {31'd0, m0_valid}, {31'd0, fin && (own == 0)});
        chk("m1_valid", {31'd0, m1_valid}, {31'd0, fin && (own == 1)});
        if (own >= 0) begin
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_write_data", mem_write_data, e_wd);
            chk("mem_byte_en", {28'd0, mem_byte_en}, {28'd0, e_be});
        end
        if (own != 0 || fin) chk("m0_read_data", m0_read_data, (own == 0) ? e_rd : 32'h0);
        if (own != 1 || fin) chk("m1_read_data", m1_read_data, (own == 1) ? e_rd : 32'h0);

        if (grant == 2'b01) cnt_g0++;
        if (m0_valid) cnt_v0++;
        if (m1_valid) begin
            cnt_v1++;
            last_v1_rdata = m1_read_data;
        end
        if (mem_req && mem_write_en && mem_valid && mem_addr == 32'h100 &&
            mem_write_data == 32'hDEAD_BEEF) cnt_memw++;
        if (timeout_err) cnt_to++;
        if (prev_grant == 2'b00 && grant != 2'b00) order.push_back(grant);
        prev_grant = grant;
        if (fp_grant == 2'b01) fp_g0++;
        if (fp_grant == 2'b10) fp_g1++;

        if (own < 0) begin
            if (m0_req || m1_req) begin
                if (m0_req && m1_req) own = (last == 0) ? 1 : 0;
                else                  own = m1_req ? 1 : 0;
                last      = own;
                k         = 0;
                lat       = next_lat;
                txn_rdata = use_fixed ? fixed_rdata : $urandom;
            end
        end else if (fin) begin
            own = -1;
        end else begin
            k++;
        end
        @(posedge clk);
        #1;
    endtask

    // Run from an IDLE cycle with a request pending until the model completes.
    task automatic run_txn();
        step();
        for (int i = 0; i < 40 && own >= 0; i++) step();
    endtask

    task automatic clear_counts();
        cnt_g0 = 0; cnt_v0 = 0; cnt_v1 = 0; cnt_memw = 0; cnt_to = 0;
        order.delete();
    endtask

    task automatic applyStimulus();
        m0_req = 1'b0; m0_write_en = 1'b0; m0_addr = 32'h0; m0_write_data = 32'h0; m0_byte_en = 4'h0;
        m1_req = 1'b0; m1_write_en = 1'b0; m1_addr = 32'h0; m1_write_data = 32'h0; m1_byte_en = 4'h0;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "_grant"}, {30'd0, grant}, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_write_en}, 32'd0);
        chk({tag, "_valids"}, {30'd0, m0_valid, m1_valid}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        res = 1'b1;
        fp_m0_req = 1'b1;
        fp_m1_req = 1'b1;
        mem_valid = 1'b0;
        mem_read_data = 32'h0;
        use_fixed = 1'b0;
        fixed_rdata = 32'h0;
        next_lat = 1;
        lat = 0;
        txn_rdata = 32'h0;
        prev_grant = 2'b00;
        last_v1_rdata = 32'h0;
        fp_g0 = 0; fp_g1 = 0;
        applyStimulus();
        clear_counts();
        model_reset();

        #12;
        checkOutput("reset");
        @(posedge clk); #1;
        res = 1'b0;

        // m0 single write, memory acknowledges on the fourth BUSY cycle.
        clear_counts();
        m0_req = 1'b1; m0_write_en = 1'b1; m0_addr = 32'h100;
        m0_write_data = 32'hDEAD_BEEF; m0_byte_en = 4'hF;
        next_lat = 3;
        run_txn();
        m0_req = 1'b0; m0_write_en = 1'b0;
        step();
        chk("t1_grant_cycles", cnt_g0, 4);
        chk("t1_m0_valid_count", cnt_v0, 1);
        chk("t1_m1_valid_count", cnt_v1, 0);
        chk("t1_mem_write_count", cnt_memw, 1);

        // m1 read returning a fixed word.
        clear_counts();
        use_fixed = 1'b1; fixed_rdata = 32'h1234_5678;
        m1_req = 1'b1; m1_addr = 32'h200; m1_byte_en = 4'hF;
        next_lat = 2;
        run_txn();
        m1_req = 1'b0;
        use_fixed = 1'b0;
        step();
        chk("t2_m1_valid_count", cnt_v1, 1);
        chk("t2_m1_read_data", last_v1_rdata, 32'h1234_5678);

        // Round-robin alternation from a fresh reset.
        res = 1'b1; #1;
        @(posedge clk); #1;
        res = 1'b0;
        model_reset();
        prev_grant = 2'b00;
        clear_counts();
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 80 && order.size() < 6; i++) begin
            next_lat = $urandom_range(0, 3);
            step();
        end
        while (own >= 0) step();
        chk("t3_txn_count", order.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_order_%0d", i), {30'd0, order_at(i)},
                (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        // Watchdog: memory never answers m0, then m1 gets the bus.
        clear_counts();
        next_lat = 100;
        run_txn();
        next_lat = 1;
        run_txn();
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        chk("t4_timeout_pulses", cnt_to, 1);
        chk("t4_first_owner", {30'd0, order_at(0)}, 32'd1);
        chk("t4_next_owner", {30'd0, order_at(1)}, 32'd2);

        // Valid on the last watchdog cycle completes normally.
        clear_counts();
        m0_req = 1'b1;
        next_lat = TO - 1;
        run_txn();
        m0_req = 1'b0;
        step();
        chk("t6_timeout_pulses", cnt_to, 0);
        chk("t6_m0_valid_count", cnt_v0, 1);

        // Asynchronous reset in the middle of a transaction.
        m0_req = 1'b1;
        next_lat = 50;
        step();
        step();
        #2;
        res = 1'b1;
        #1;
        checkOutput("t5_async");
        @(posedge clk); #1;
        res = 1'b0;
        model_reset();
        m0_req = 1'b0; m1_req = 1'b1;
        step();
        step();
        chk("t5_grant_after_release", {30'd0, grant}, 32'd2);
        while (own >= 0) step();
        m1_req = 1'b0;
        step();

        // Randomised traffic checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            m0_req = ($urandom_range(0, 3) != 0);
            m1_req = ($urandom_range(0, 2) != 0);
            m0_write_en = $urandom_range(0, 1);
            m1_write_en = $urandom_range(0, 1);
            m0_addr = $urandom; m1_addr = $urandom;
            m0_write_data = $urandom; m1_write_data = $urandom;
            m0_byte_en = 4'($urandom); m1_byte_en = 4'($urandom);
            next_lat = $urandom_range(0, 10);
            step();
        end

        chk("fp_m1_starved", fp_g1, 0);
        chk("fp_m0_served", {31'd0, fp_g0 > 100}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
